// File: rtl/operand_fetch.sv
// Operand fetch: register-file read addressing, ID/EX pipeline register,
// load-use stall detection and EX/MEM, MEM/WB operand forwarding.
module operand_fetch #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_id_valid,
    input  logic [AW-1:0]   i_id_rs1,
    input  logic [AW-1:0]   i_id_rs2,
    input  logic [AW-1:0]   i_id_rd,
    input  logic            i_id_reg_write,
    input  logic            i_id_mem_read,
    output logic [AW-1:0]   o_rr1,
    output logic [AW-1:0]   o_rr2,
    input  logic [XLEN-1:0] i_rf_rd1,
    input  logic [XLEN-1:0] i_rf_rd2,
    input  logic            i_flush,
    input  logic            i_ex_hold,
    input  logic            i_mem_reg_write,
    input  logic [AW-1:0]   i_mem_rd,
    input  logic [XLEN-1:0] i_mem_result,
    input  logic            i_wb_reg_write,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_stall,
    output logic            o_ex_valid,
    output logic [AW-1:0]   o_ex_rd,
    output logic            o_ex_reg_write,
    output logic            o_ex_mem_read,
    output logic [XLEN-1:0] o_ex_op_a,
    output logic [XLEN-1:0] o_ex_op_b
);

    logic            r_valid;
    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rs2;
    logic [AW-1:0]   r_rd;
    logic            r_reg_write;
    logic            r_mem_read;
    logic [XLEN-1:0] r_v1;
    logic [XLEN-1:0] r_v2;

    logic            w_hazard;
    logic            w_bubble;

    assign o_rr1 = i_id_rs1;
    assign o_rr2 = i_id_rs2;

    assign w_hazard = r_valid && r_mem_read && (r_rd != '0) && i_id_valid &&
                      ((r_rd == i_id_rs1) || (r_rd == i_id_rs2));
    assign w_bubble = i_flush || w_hazard;
    assign o_stall  = (w_hazard || i_ex_hold) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_v1        <= '0;
            r_v2        <= '0;
        end else if (!i_ex_hold) begin
            // Bubble only clears the control bits; the data fields are don't-care.
            r_valid     <= w_bubble ? 1'b0 : i_id_valid;
            r_reg_write <= w_bubble ? 1'b0 : i_id_reg_write;
            r_mem_read  <= w_bubble ? 1'b0 : i_id_mem_read;
            r_rs1       <= i_id_rs1;
            r_rs2       <= i_id_rs2;
            r_rd        <= i_id_rd;
            r_v1        <= i_rf_rd1;
            r_v2        <= i_rf_rd2;
        end
    end

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] v,
        input logic            mem_we,
        input logic [AW-1:0]   mem_rd,
        input logic [XLEN-1:0] mem_res,
        input logic            wb_we,
        input logic [AW-1:0]   wb_rd,
        input logic [XLEN-1:0] wb_dat
    );
        logic [XLEN-1:0] res;
        // rs==0 is tested first, so a source with rd==0 can never match.
        if (rs == '0) begin
            res = '0;
        end else if (mem_we && (mem_rd == rs)) begin
            res = mem_res;
        end else if (wb_we && (wb_rd == rs)) begin
            res = wb_dat;
        end else begin
            res = v;
        end
        return res;
    endfunction

    always_comb begin
        o_ex_op_a = fwd_sel(r_rs1, r_v1, i_mem_reg_write, i_mem_rd, i_mem_result,
                            i_wb_reg_write, i_wb_rd, i_wb_data);
        o_ex_op_b = fwd_sel(r_rs2, r_v2, i_mem_reg_write, i_mem_rd, i_mem_result,
                            i_wb_reg_write, i_wb_rd, i_wb_data);
    end

    assign o_ex_valid     = r_valid;
    assign o_ex_rd        = r_rd;
    assign o_ex_reg_write = r_reg_write;
    assign o_ex_mem_read  = r_mem_read;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal checks, plus a
// per-cycle comparison against a behavioural model of the ID/EX stage.
module tb_operand_fetch;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_reg_write, id_mem_read;
    logic [AW-1:0]   id_rs1, id_rs2, id_rd;
    logic [AW-1:0]   rr1, rr2;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic            flush, ex_hold;
    logic            mem_reg_write, wb_reg_write;
    logic [AW-1:0]   mem_rd, wb_rd;
    logic [XLEN-1:0] mem_result, wb_data;
    logic            stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_op_a, ex_op_b;

    logic [XLEN-1:0] regs [32];
    int              n_checks = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_rd1 = regs[rr1];
    assign rf_rd2 = regs[rr2];

    operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
        .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
        .o_rr1(rr1), .o_rr2(rr2), .i_rf_rd1(rf_rd1), .i_rf_rd2(rf_rd2),
        .i_flush(flush), .i_ex_hold(ex_hold),
        .i_mem_reg_write(mem_reg_write), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
        .i_wb_reg_write(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_stall(stall), .o_ex_valid(ex_valid), .o_ex_rd(ex_rd),
        .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read),
        .o_ex_op_a(ex_op_a), .o_ex_op_b(ex_op_b)
    );

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the instruction currently sitting in EX.
    typedef struct {
        logic            valid;
        logic [AW-1:0]   rs1, rs2, rd;
        logic            we, ld;
        logic [XLEN-1:0] v1, v2;
    } instr_t;

    instr_t m_ex;
    logic   m_init = 1'b0;
    logic   m_ops_known = 1'b0;

    function automatic logic m_load_use();
        return m_ex.valid && m_ex.ld && m_ex.rd != 0 && id_valid &&
               (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
    endfunction

    function automatic logic [XLEN-1:0] m_operand(input logic [AW-1:0] rs,
                                                  input logic [XLEN-1:0] v);
        if (rs == 0) return '0;
        if (mem_reg_write && mem_rd == rs) return mem_result;
        if (wb_reg_write && wb_rd == rs) return wb_data;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ex <= '{valid: 1'b0, rs1: '0, rs2: '0, rd: '0, we: 1'b0, ld: 1'b0,
                      v1: '0, v2: '0};
            m_init      <= 1'b1;
            m_ops_known <= 1'b1;
        end else if (ex_hold) begin
            m_ex <= m_ex;
        end else if (flush || m_load_use()) begin
            m_ex.valid  <= 1'b0;
            m_ex.we     <= 1'b0;
            m_ex.ld     <= 1'b0;
            m_ops_known <= 1'b0;
        end else begin
            m_ex <= '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      we: id_reg_write, ld: id_mem_read, v1: regs[id_rs1], v2: regs[id_rs2]};
            m_ops_known <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_rr1", {27'b0, rr1}, {27'b0, id_rs1});
            chk("model_rr2", {27'b0, rr2}, {27'b0, id_rs2});
            chk("model_stall", {31'b0, stall}, {31'b0, (m_load_use() || ex_hold) && !flush});
            chk("model_ex_valid", {31'b0, ex_valid}, {31'b0, m_ex.valid});
            chk("model_ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_ex.we});
            chk("model_ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m_ex.ld});
            if (m_ex.valid) chk("model_ex_rd", {27'b0, ex_rd}, {27'b0, m_ex.rd});
            if (m_ops_known) begin
                chk("model_op_a", ex_op_a, m_operand(m_ex.rs1, m_ex.v1));
                chk("model_op_b", ex_op_b, m_operand(m_ex.rs2, m_ex.v2));
            end
        end
    end

    task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = we; id_mem_read = ld;
    endtask

    task automatic clr_fwd();
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        regs[0] = '0;
        regs[3] = 32'h11;
        rst = 1; flush = 0; ex_hold = 0;
        set_id(0, 0, 0, 0, 0, 0);
        clr_fwd();

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_op_a", ex_op_a, 32'h0);
        chk("rst_op_b", ex_op_b, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // Plain capture, one-cycle latency
        set_id(1, 3, 4, 6, 1, 0);
        tick();
        set_id(0, 3, 4, 6, 0, 0);
        chk("cap_ex_valid", {31'b0, ex_valid}, 32'h1);
        chk("cap_op_a", ex_op_a, 32'h11);
        chk("cap_op_b", ex_op_b, 32'h104);

        // Forward priority, with ex_hold freezing ID/EX
        ex_hold = 1;
        mem_reg_write = 1; mem_rd = 3; mem_result = 32'hAA;
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'hBB;
        #1 chk("fwd_mem_wins", ex_op_a, 32'hAA);
        chk("hold_stall", {31'b0, stall}, 32'h1);
        mem_reg_write = 0;
        #1 chk("fwd_wb", ex_op_a, 32'hBB);
        tick();
        chk("hold_keeps_valid", {31'b0, ex_valid}, 32'h1);
        chk("hold_keeps_rd", {27'b0, ex_rd}, 32'h6);
        ex_hold = 0;
        clr_fwd();

        // x0 is never forwarded
        set_id(1, 0, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'hFF;
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'hEE;
        #1 chk("x0_op_a", ex_op_a, 32'h0);
        chk("x0_op_b", ex_op_b, 32'h0);
        clr_fwd();

        // Load-use: one bubble, then forwarded operand
        set_id(1, 1, 2, 5, 1, 1);
        tick();
        set_id(1, 6, 5, 7, 1, 0);
        #1 chk("lu_stall", {31'b0, stall}, 32'h1);
        tick();
        chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
        chk("lu_stall_clears", {31'b0, stall}, 32'h0);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        wb_reg_write = 1; wb_rd = 5; wb_data = 32'h55;
        #1 chk("lu_issue_valid", {31'b0, ex_valid}, 32'h1);
        chk("lu_op_b_fwd", ex_op_b, 32'h55);
        chk("lu_op_a", ex_op_a, 32'h106);
        clr_fwd();

        // Hazard and flush together: flush wins
        set_id(1, 1, 2, 5, 1, 1);
        tick();
        set_id(1, 6, 5, 7, 1, 0);
        flush = 1;
        #1 chk("flush_stall", {31'b0, stall}, 32'h0);
        tick();
        flush = 0;
        set_id(0, 0, 0, 0, 0, 0);
        chk("flush_bubble", {31'b0, ex_valid}, 32'h0);

        // Hazard under ex_hold: load retained, single bubble afterwards
        set_id(1, 1, 2, 5, 1, 1);
        tick();
        set_id(1, 6, 5, 7, 1, 0);
        ex_hold = 1;
        #1 chk("hh_stall", {31'b0, stall}, 32'h1);
        tick();
        chk("hh_valid", {31'b0, ex_valid}, 32'h1);
        chk("hh_mem_read", {31'b0, ex_mem_read}, 32'h1);
        chk("hh_rd", {27'b0, ex_rd}, 32'h5);
        ex_hold = 0;
        #1 chk("hh_hazard_persists", {31'b0, stall}, 32'h1);
        tick();
        chk("hh_bubble", {31'b0, ex_valid}, 32'h0);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        chk("hh_issue", {31'b0, ex_valid}, 32'h1);
        chk("hh_issue_rd", {27'b0, ex_rd}, 32'h7);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
